seg_display_scan: RTL

Parametrised multiplexed 7-segment driver for the DDR game board, the successor to the fixed 4-digit display block. It drives N digits from either a packed glyph vector (arrow/digit codes during play) or a binary value converted to decimal by an internal sequential double-dabble engine (score/combo). Results are committed to a frame buffer atomically, so the scan never shows a half-updated frame. It sits between the game FSM and the board seg/an pins.

---
 rtl/seg_display_scan.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_display_scan.sv
// Multiplexed N-digit 7-segment driver: glyph or binary-to-BCD number frames committed atomically.
// Optional blink support is compiled in with `define DISP_BLINK_EN.
module seg_display_scan #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned GLYPH_BITS   = 5,
  parameter int unsigned VALUE_BITS   = 14,
  parameter int unsigned REFRESH_DIV  = 100000
`ifdef DISP_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 32
`endif
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             update,
  input  logic                             mode,
  input  logic [NUM_DIGITS*GLYPH_BITS-1:0] glyph_in,
  input  logic [VALUE_BITS-1:0]            value_in,
  input  logic                             lz_blank,
`ifdef DISP_BLINK_EN
  input  logic [NUM_DIGITS-1:0]            blink_mask,
`endif
  output logic                             busy,
  output logic                             overflow,
  output logic [6:0]                       seg,
  output logic [NUM_DIGITS-1:0]            an
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned BIT_W = $clog2(VALUE_BITS + 1);
  localparam int unsigned BCD_W = 4 * (NUM_DIGITS + 1);
  localparam int unsigned BUF_W = NUM_DIGITS * GLYPH_BITS;

  localparam logic [GLYPH_BITS-1:0] GLYPH_BLANK = '1;

  localparam logic [6:0] SEG_BLANK            = 7'h7F;
  localparam logic [6:0] SEG_ZERO             = 7'h40;
  localparam logic [6:0] SEG_ONE              = 7'h79;
  localparam logic [6:0] SEG_TWO              = 7'h24;
  localparam logic [6:0] SEG_THREE            = 7'h30;
  localparam logic [6:0] SEG_FOUR             = 7'h19;
  localparam logic [6:0] SEG_FIVE             = 7'h12;
  localparam logic [6:0] SEG_SIX              = 7'h02;
  localparam logic [6:0] SEG_SEVEN            = 7'h78;
  localparam logic [6:0] SEG_EIGHT            = 7'h00;
  localparam logic [6:0] SEG_NINE             = 7'h10;
  localparam logic [6:0] SEG_ARROW_UP         = 7'h7E;
  localparam logic [6:0] SEG_ARROW_DOWN       = 7'h77;
  localparam logic [6:0] SEG_ARROW_LEFT       = 7'h4F;
  localparam logic [6:0] SEG_ARROW_RIGHT      = 7'h39;
  localparam logic [6:0] SEG_ARROW_UP_DOWN    = 7'h76;
  localparam logic [6:0] SEG_ARROW_UP_LEFT    = 7'h4E;
  localparam logic [6:0] SEG_ARROW_UP_RIGHT   = 7'h7C;
  localparam logic [6:0] SEG_ARROW_DOWN_LEFT  = 7'h67;
  localparam logic [6:0] SEG_ARROW_DOWN_RIGHT = 7'h73;
  localparam logic [6:0] SEG_ARROW_LEFT_RIGHT = 7'h5D;
  localparam logic [6:0] SEG_ARROW_NONE       = 7'h3F;

  function automatic logic [6:0] glyph_to_seg(input logic [GLYPH_BITS-1:0] code);
    logic [6:0] s;
    s = SEG_BLANK;
    case (32'(code))
      0:  s = SEG_ZERO;
      1:  s = SEG_ONE;
      2:  s = SEG_TWO;
      3:  s = SEG_THREE;
      4:  s = SEG_FOUR;
      5:  s = SEG_FIVE;
      6:  s = SEG_SIX;
      7:  s = SEG_SEVEN;
      8:  s = SEG_EIGHT;
      9:  s = SEG_NINE;
      10: s = SEG_ARROW_UP;
      11: s = SEG_ARROW_DOWN;
      12: s = SEG_ARROW_LEFT;
      13: s = SEG_ARROW_RIGHT;
      14: s = SEG_ARROW_UP_DOWN;
      15: s = SEG_ARROW_UP_LEFT;
      16: s = SEG_ARROW_UP_RIGHT;
      17: s = SEG_ARROW_DOWN_LEFT;
      18: s = SEG_ARROW_DOWN_RIGHT;
      19: s = SEG_ARROW_LEFT_RIGHT;
      20: s = SEG_ARROW_NONE;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [BUF_W-1:0]      buf_q;
  logic [PRE_W-1:0]      pre_q;
  logic [IDX_W-1:0]      idx_q;
  logic [BIT_W-1:0]      bit_q;
  logic [VALUE_BITS-1:0] bin_q;
  logic [BCD_W-1:0]      bcd_q;
  logic                  lz_q;
  logic                  carry_q;

  logic                  tick_c;
  logic                  last_c;
  logic                  blank_c;
  logic [GLYPH_BITS-1:0] cur_glyph_c;
  logic [BCD_W-1:0]      bcd_adj_c;
  logic [BCD_W-1:0]      bcd_next_c;
  logic                  ovf_c;
  logic                  seen_c;
  logic [3:0]            dig_c;
  logic [BUF_W-1:0]      commit_c;

  assign tick_c      = (pre_q == PRE_W'(REFRESH_DIV - 1));
  assign last_c      = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign cur_glyph_c = buf_q[32'(idx_q) * GLYPH_BITS +: GLYPH_BITS];

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next_c = {bcd_adj_c[BCD_W-2:0], bin_q[VALUE_BITS-1]};
  end

  // Carry out of the guard digit or a nonzero guard digit means more digits than are displayed.
  assign ovf_c = carry_q | bcd_adj_c[BCD_W-1] | (bcd_next_c[BCD_W-1 -: 4] != 4'd0);

  // Frame to commit when the conversion finishes, with leading zeros optionally blanked.
  always_comb begin
    commit_c = '0;
    seen_c   = 1'b0;
    dig_c    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      dig_c = bcd_next_c[4*i +: 4];
      if (dig_c != 4'd0) seen_c = 1'b1;
      if (ovf_c)                          commit_c[i*GLYPH_BITS +: GLYPH_BITS] = GLYPH_BITS'(9);
      else if (lz_q && !seen_c && i != 0) commit_c[i*GLYPH_BITS +: GLYPH_BITS] = GLYPH_BLANK;
      else                                commit_c[i*GLYPH_BITS +: GLYPH_BITS] = GLYPH_BITS'(dig_c);
    end
  end

  // Update acceptance, number conversion and atomic frame commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      overflow <= 1'b0;
      buf_q    <= '1;
      bit_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      lz_q     <= 1'b0;
      carry_q  <= 1'b0;
    end else if (busy) begin
      bcd_q   <= bcd_next_c;
      bin_q   <= bin_q << 1;
      bit_q   <= bit_q + BIT_W'(1);
      carry_q <= carry_q | bcd_adj_c[BCD_W-1];
      if (bit_q == BIT_W'(VALUE_BITS - 1)) begin
        busy     <= 1'b0;
        buf_q    <= commit_c;
        overflow <= ovf_c;
      end
    end else if (update) begin
      if (mode) begin
        busy    <= 1'b1;
        bin_q   <= value_in;
        bcd_q   <= '0;
        bit_q   <= '0;
        lz_q    <= lz_blank;
        carry_q <= 1'b0;
      end else begin
        buf_q    <= glyph_in;
        overflow <= 1'b0;
      end
    end
  end

  // Digit scan: present the current digit on the terminal count, then advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
      an    <= '1;
      seg   <= SEG_BLANK;
    end else begin
      pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
      if (tick_c) begin
        an    <= ~(NUM_DIGITS'(1) << idx_q);
        seg   <= blank_c ? SEG_BLANK : glyph_to_seg(cur_glyph_c);
        idx_q <= last_c ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

`ifdef DISP_BLINK_EN
  localparam int unsigned FRM_W = $clog2(BLINK_FRAMES) + 1;

  logic [FRM_W-1:0] frame_q;
  logic             blink_off_q;

  // Blink phase flips after every BLINK_FRAMES completed scan frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q     <= '0;
      blink_off_q <= 1'b0;
    end else if (tick_c && last_c) begin
      if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_q     <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        frame_q <= frame_q + FRM_W'(1);
      end
    end
  end

  assign blank_c = blink_off_q & blink_mask[idx_q];
`else
  assign blank_c = 1'b0;
`endif

endmodule
